// File: rtl/dram_read_master_pkg.sv
// Shared AXI constants, FSM state type and the 4 KB page-crossing helper
// for the image pipeline's DRAM read master.
package image_dram_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int BEAT_BYTES = 16;
  localparam int PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_t;

  // Evaluated in 13 bits so that a full 256-beat burst from the top of a page still fits.
  function automatic logic crosses_page(input logic [11:0] offs, input logic [7:0] len);
    logic [12:0] end_byte;
    end_byte = {1'b0, offs} + (({5'b0, len} + 13'd1) * 13'(BEAT_BYTES));
    return end_byte > 13'(PAGE_BYTES);
  endfunction

endpackage

// File: rtl/dram_read_master_if.sv
// Request/beat side towards the image controller and buffer, AR/R side towards
// the PS DDR port, plus the sticky status flags.
interface dram_read_master_if #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH    = 16
);
  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr;
  logic [7:0]                 dram_read_len;
  logic                       dram_read_en;
  logic                       dram_buffer_full;
  logic [DRAM_DATA_WIDTH-1:0] dram_read_data;
  logic                       dram_read_data_valid;
  logic                       dram_read_busy;

  logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                 m_axi_arlen;
  logic [2:0]                 m_axi_arsize;
  logic [1:0]                 m_axi_arburst;
  logic [AXI_ID_WIDTH-1:0]    m_axi_arid;
  logic                       m_axi_arvalid;
  logic                       m_axi_arready;
  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                 m_axi_rresp;
  logic                       m_axi_rlast;
  logic [AXI_ID_WIDTH-1:0]    m_axi_rid;
  logic                       m_axi_rvalid;
  logic                       m_axi_rready;

  logic                       error_clear;
  logic                       read_error;
  logic                       boundary_error;
  logic                       req_dropped;

  modport master (
    input  dram_read_addr, dram_read_len, dram_read_en, dram_buffer_full,
    output dram_read_data, dram_read_data_valid, dram_read_busy,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
    output m_axi_rready,
    input  error_clear,
    output read_error, boundary_error, req_dropped
  );

  modport slave (
    output dram_read_addr, dram_read_len, dram_read_en, dram_buffer_full,
    input  dram_read_data, dram_read_data_valid, dram_read_busy,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
    input  m_axi_rready,
    output error_clear,
    input  read_error, boundary_error, req_dropped
  );
endinterface

// File: rtl/dram_read_master.sv
// AXI4 read master: one burst in flight plus a one-deep pending slot, beats
// forwarded to the image buffer with one cycle of latency.
module dram_read_master
  import image_dram_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH    = 16,
  parameter int AXI_ID          = 0
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  dram_read_master_if.master   bus
);

  localparam int AW = DRAM_ADDR_WIDTH;
  localparam int DW = DRAM_DATA_WIDTH;

  rd_state_t         state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [AW-1:0]     pend_addr_q, pend_addr_d;
  logic [7:0]        pend_len_q, pend_len_d;
  logic [AW-1:0]     cur_addr_q, cur_addr_d;
  logic [7:0]        cur_len_q, cur_len_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              busy_q, busy_d;
  logic              read_err_q, read_err_d;
  logic              bound_err_q, bound_err_d;
  logic              drop_q, drop_d;

  logic              r_hs;
  logic              last_beat;
  logic              latch_en;
  logic              take_pend;
  logic              en_to_pend;
  logic [AW-1:0]     latch_addr;
  logic [7:0]        latch_len;
  logic [AW-1:0]     aligned_addr;
  logic              read_err_set;
  logic              bound_err_set;
  logic              drop_set;

  assign r_hs      = (state_q == DATA) && bus.m_axi_rvalid && !bus.dram_buffer_full;
  assign last_beat = r_hs && bus.m_axi_rlast;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_len_q   <= '0;
      cur_addr_q   <= '0;
      cur_len_q    <= '0;
      beat_cnt_q   <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      read_err_q   <= 1'b0;
      bound_err_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_len_q   <= pend_len_d;
      cur_addr_q   <= cur_addr_d;
      cur_len_q    <= cur_len_d;
      beat_cnt_q   <= beat_cnt_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      busy_q       <= busy_d;
      read_err_q   <= read_err_d;
      bound_err_q  <= bound_err_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pend_valid_q || bus.dram_read_en) state_d = ADDR;
      ADDR: if (bus.m_axi_arready) state_d = DATA;
      DATA: if (last_beat) state_d = pend_valid_q ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_addr_d   = pend_addr_q;
    pend_len_d    = pend_len_q;
    cur_addr_d    = cur_addr_q;
    cur_len_d     = cur_len_q;
    beat_cnt_d    = beat_cnt_q;
    rdata_d       = rdata_q;
    rvalid_d      = r_hs;
    latch_en      = 1'b0;
    take_pend     = 1'b0;
    latch_addr    = pend_addr_q;
    latch_len     = pend_len_q;
    read_err_set  = 1'b0;
    bound_err_set = 1'b0;
    drop_set      = 1'b0;

    // The pending slot always wins over a fresh strobe; the strobe then queues behind it.
    if (state_q == IDLE) begin
      latch_en = pend_valid_q || bus.dram_read_en;
      if (pend_valid_q) begin
        take_pend = 1'b1;
      end else begin
        latch_addr = bus.dram_read_addr;
        latch_len  = bus.dram_read_len;
      end
    end else if (last_beat && pend_valid_q) begin
      latch_en  = 1'b1;
      take_pend = 1'b1;
    end

    aligned_addr = {latch_addr[AW-1:4], 4'b0000};
    if (latch_en) begin
      cur_addr_d    = aligned_addr;
      cur_len_d     = latch_len;
      bound_err_set = crosses_page(aligned_addr[11:0], latch_len);
    end

    en_to_pend = bus.dram_read_en && !((state_q == IDLE) && !pend_valid_q);
    if (take_pend) pend_valid_d = 1'b0;
    if (en_to_pend) begin
      if (!pend_valid_q || take_pend) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = bus.dram_read_addr;
        pend_len_d   = bus.dram_read_len;
      end else begin
        drop_set = 1'b1;
      end
    end

    if ((state_q == ADDR) && bus.m_axi_arready) beat_cnt_d = '0;
    if (r_hs) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
      rdata_d    = bus.m_axi_rdata;
      if (bus.m_axi_rresp != RESP_OKAY) read_err_set = 1'b1;
      if (bus.m_axi_rlast != (beat_cnt_q == cur_len_q)) read_err_set = 1'b1;
    end

    busy_d      = (state_d != IDLE) || pend_valid_d;
    read_err_d  = read_err_set  ? 1'b1 : (bus.error_clear ? 1'b0 : read_err_q);
    bound_err_d = bound_err_set ? 1'b1 : (bus.error_clear ? 1'b0 : bound_err_q);
    drop_d      = drop_set      ? 1'b1 : (bus.error_clear ? 1'b0 : drop_q);
  end

  always_comb begin
    bus.m_axi_arvalid = (state_q == ADDR);
    bus.m_axi_rready  = (state_q == DATA) && !bus.dram_buffer_full;
  end

  assign bus.m_axi_araddr         = cur_addr_q;
  assign bus.m_axi_arlen          = cur_len_q;
  assign bus.m_axi_arsize         = SIZE_16B;
  assign bus.m_axi_arburst        = BURST_INCR;
  assign bus.m_axi_arid           = AXI_ID_WIDTH'(AXI_ID);
  assign bus.dram_read_data       = rdata_q;
  assign bus.dram_read_data_valid = rvalid_q;
  assign bus.dram_read_busy       = busy_q;
  assign bus.read_error           = read_err_q;
  assign bus.boundary_error       = bound_err_q;
  assign bus.req_dropped          = drop_q;

  logic unused_bits;
  assign unused_bits = ^{bus.m_axi_rid, latch_addr[3:0]};

endmodule

// File: tb/tb_dram_read_master.sv
// Directed bench for dram_read_master: single burst, backpressure, queueing,
// error flags, 4 KB boundary and asynchronous reset mid-burst.
module tb_dram_read_master;
  import image_dram_pkg::*;

  localparam int AW = 39;
  localparam int DW = 128;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  always #5 clk = ~clk;

  dram_read_master_if #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

  dram_read_master #(
    .DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_ID(0)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .bus          (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int burst, input int idx);
    return {16'hBEEF, 8'(burst), 8'(idx), 96'h0123_4567_89AB_CDEF_5A5A_A5A5};
  endfunction

  task automatic request(input logic [AW-1:0] a, input logic [7:0] l);
    bus.dram_read_en   = 1'b1;
    bus.dram_read_addr = a;
    bus.dram_read_len  = l;
    tick();
    bus.dram_read_en   = 1'b0;
  endtask

  task automatic ar_accept();
    bus.m_axi_arready = 1'b1;
    tick();
    bus.m_axi_arready = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last, input logic [1:0] resp);
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = d;
    bus.m_axi_rlast  = last;
    bus.m_axi_rresp  = resp;
    tick();
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast  = 1'b0;
    bus.m_axi_rresp  = 2'b00;
  endtask

  task automatic clear_errors();
    bus.error_clear = 1'b1;
    tick();
    bus.error_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dram_read_addr   = '0;
    bus.dram_read_len    = '0;
    bus.dram_read_en     = 1'b0;
    bus.dram_buffer_full = 1'b0;
    bus.m_axi_arready    = 1'b0;
    bus.m_axi_rdata      = '0;
    bus.m_axi_rresp      = 2'b00;
    bus.m_axi_rlast      = 1'b0;
    bus.m_axi_rid        = '0;
    bus.m_axi_rvalid     = 1'b0;
    bus.error_clear      = 1'b0;

    // Reset state
    #12;
    check("rst_arvalid", bus.m_axi_arvalid, 0);
    check("rst_busy", bus.dram_read_busy, 0);
    check("rst_valid", bus.dram_read_data_valid, 0);
    check("rst_rready", bus.m_axi_rready, 0);
    check("rst_araddr", bus.m_axi_araddr, 0);
    check("rst_flags", {bus.read_error, bus.boundary_error, bus.req_dropped}, 0);
    check("rst_arsize", bus.m_axi_arsize, 3'b100);
    check("rst_arburst", bus.m_axi_arburst, 2'b01);
    check("rst_arid", bus.m_axi_arid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single burst: addr 0x1000, len 3, arready on the third AR cycle
    request(39'h1000, 8'd3);
    check("t1_arvalid_c1", bus.m_axi_arvalid, 1);
    check("t1_araddr", bus.m_axi_araddr, 39'h1000);
    check("t1_arlen", bus.m_axi_arlen, 8'd3);
    check("t1_busy", bus.dram_read_busy, 1);
    check("t1_rready_addr", bus.m_axi_rready, 0);
    tick();
    check("t1_arvalid_c2", bus.m_axi_arvalid, 1);
    tick();
    check("t1_arvalid_c3", bus.m_axi_arvalid, 1);
    ar_accept();
    check("t1_arvalid_done", bus.m_axi_arvalid, 0);
    check("t1_valid_idle", bus.dram_read_data_valid, 0);
    for (int i = 0; i < 4; i++) begin
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = pat(1, i);
      bus.m_axi_rlast  = (i == 3);
      #1;
      check("t1_rready", bus.m_axi_rready, 1);
      tick();
      check("t1_valid", bus.dram_read_data_valid, 1);
      check("t1_data", bus.dram_read_data, pat(1, i));
    end
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast  = 1'b0;
    check("t1_busy_drop", bus.dram_read_busy, 0);
    tick();
    check("t1_valid_end", bus.dram_read_data_valid, 0);

    // Backpressure: len 7, buffer full while beats 2 and 3 are offered
    request(39'h3000, 8'd7);
    ar_accept();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 3) begin
        bus.dram_buffer_full = 1'b1;
        bus.m_axi_rvalid     = 1'b1;
        bus.m_axi_rdata      = pat(2, i);
        #1;
        check("t2_rready_stall", bus.m_axi_rready, 0);
        tick();
        check("t2_no_dup", bus.dram_read_data_valid, 0);
        bus.dram_buffer_full = 1'b0;
      end
      beat(pat(2, i), (i == 7), 2'b00);
      if (bus.dram_read_data_valid) pulses++;
      check("t2_data", bus.dram_read_data, pat(2, i));
    end
    tick();
    check("t2_valid_end", bus.dram_read_data_valid, 0);
    check("t2_pulses", pulses, 8);
    check("t2_read_error", bus.read_error, 0);

    // Queueing: second request during DATA, third dropped
    request(39'h4000, 8'd1);
    ar_accept();
    bus.dram_read_en   = 1'b1;
    bus.dram_read_addr = 39'h2000;
    bus.dram_read_len  = 8'd0;
    beat(pat(3, 0), 1'b0, 2'b00);
    bus.dram_read_en   = 1'b0;
    check("t3_data0", bus.dram_read_data, pat(3, 0));
    check("t3_busy_a", bus.dram_read_busy, 1);
    check("t3_no_drop", bus.req_dropped, 0);
    request(39'h5000, 8'd0);
    check("t3_dropped", bus.req_dropped, 1);
    check("t3_busy_b", bus.dram_read_busy, 1);
    beat(pat(3, 1), 1'b1, 2'b00);
    check("t3_data1", bus.dram_read_data, pat(3, 1));
    check("t3_ar2_valid", bus.m_axi_arvalid, 1);
    check("t3_ar2_addr", bus.m_axi_araddr, 39'h2000);
    check("t3_ar2_len", bus.m_axi_arlen, 8'd0);
    check("t3_busy_c", bus.dram_read_busy, 1);
    ar_accept();
    check("t3_busy_d", bus.dram_read_busy, 1);
    beat(pat(4, 0), 1'b1, 2'b00);
    check("t3_data2", bus.dram_read_data, pat(4, 0));
    check("t3_busy_end", bus.dram_read_busy, 0);
    check("t3_arvalid_end", bus.m_axi_arvalid, 0);
    check("t3_read_error", bus.read_error, 0);
    clear_errors();
    check("t3_drop_clear", bus.req_dropped, 0);

    // Errors: SLVERR on beat 1
    request(39'h6000, 8'd3);
    ar_accept();
    beat(pat(5, 0), 1'b0, 2'b00);
    check("t4_err_before", bus.read_error, 0);
    beat(pat(5, 1), 1'b0, 2'b10);
    check("t4_err_resp", bus.read_error, 1);
    check("t4_err_fwd", bus.dram_read_data, pat(5, 1));
    beat(pat(5, 2), 1'b0, 2'b00);
    beat(pat(5, 3), 1'b1, 2'b00);
    check("t4_idle_busy", bus.dram_read_busy, 0);
    tick();
    check("t4_err_sticky", bus.read_error, 1);
    clear_errors();
    check("t4_err_clear", bus.read_error, 0);

    // Errors: early rlast on beat 2 of a len 3 burst
    request(39'h6100, 8'd3);
    ar_accept();
    beat(pat(6, 0), 1'b0, 2'b00);
    beat(pat(6, 1), 1'b0, 2'b00);
    check("t4_early_before", bus.read_error, 0);
    beat(pat(6, 2), 1'b1, 2'b00);
    check("t4_early_err", bus.read_error, 1);
    check("t4_early_busy", bus.dram_read_busy, 0);
    tick();
    check("t4_early_arvalid", bus.m_axi_arvalid, 0);
    check("t4_early_rready", bus.m_axi_rready, 0);
    clear_errors();
    check("t4_early_clear", bus.read_error, 0);

    // 4 KB boundary
    request(39'h0FF0, 8'd1);
    check("t5_bound_set", bus.boundary_error, 1);
    check("t5_bound_addr", bus.m_axi_araddr, 39'h0FF0);
    ar_accept();
    beat(pat(7, 0), 1'b0, 2'b00);
    beat(pat(7, 1), 1'b1, 2'b00);
    clear_errors();
    check("t5_bound_clear", bus.boundary_error, 0);
    request(39'h0FE0, 8'd1);
    check("t5_bound_exact", bus.boundary_error, 0);
    ar_accept();
    beat(pat(8, 0), 1'b0, 2'b00);
    beat(pat(8, 1), 1'b1, 2'b00);
    request(39'h0FE7, 8'd0);
    check("t5_align_addr", bus.m_axi_araddr, 39'h0FE0);
    check("t5_align_len", bus.m_axi_arlen, 8'd0);
    ar_accept();
    beat(pat(9, 0), 1'b1, 2'b00);
    check("t5_read_error", bus.read_error, 0);
    clear_errors();

    // Reset mid-burst after beat 1 of 4
    request(39'h7000, 8'd3);
    ar_accept();
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = pat(10, 0);
    tick();
    check("t6_valid_pre", bus.dram_read_data_valid, 1);
    bus.m_axi_rdata  = pat(10, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.dram_read_data_valid, 0);
    check("t6_rst_data", bus.dram_read_data, 0);
    check("t6_rst_busy", bus.dram_read_busy, 0);
    check("t6_rst_arvalid", bus.m_axi_arvalid, 0);
    check("t6_rst_rready", bus.m_axi_rready, 0);
    check("t6_rst_araddr", bus.m_axi_araddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_post_rready", bus.m_axi_rready, 0);
    check("t6_post_valid", bus.dram_read_data_valid, 0);
    check("t6_post_busy", bus.dram_read_busy, 0);
    bus.m_axi_rvalid = 1'b0;
    request(39'h8000, 8'd0);
    check("t6_new_arvalid", bus.m_axi_arvalid, 1);
    check("t6_new_araddr", bus.m_axi_araddr, 39'h8000);
    ar_accept();
    beat(pat(11, 0), 1'b1, 2'b00);
    check("t6_new_valid", bus.dram_read_data_valid, 1);
    check("t6_new_data", bus.dram_read_data, pat(11, 0));
    check("t6_new_busy", bus.dram_read_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_read_master.md
Name: dram_read_master

Overview:
- AXI4 read master that turns the single-cycle burst requests from the image pipeline into AR/R transactions on the PS DDR port.
- Sits directly downstream of the image controller's `dram_read_*` interface, between the image controller and the AXI interconnect.
- Returns 128-bit beats to the image buffer and honours that buffer's full flag.
- One burst is outstanding at a time, and one further request can be queued.

Parameters:
- DRAM_ADDR_WIDTH, 39, byte address width of the DDR port
- DRAM_DATA_WIDTH, 128, data width of R beats and of `dram_read_data`
- AXI_ID_WIDTH, 16, width of `m_axi_arid` / `m_axi_rid`
- AXI_ID, 0, constant ID driven on AR

Ports:
- s_axi_aclk  in  1  single clock for the whole block
- s_axi_aresetn  in  1  asynchronous, active-low reset
- dram_read_addr  in  DRAM_ADDR_WIDTH  burst start byte address
- dram_read_len  in  8  beats minus one (AXI encoding)
- dram_read_en  in  1  one-cycle request strobe
- dram_buffer_full  in  1  consumer cannot accept a beat
- dram_read_data  out  DRAM_DATA_WIDTH  returned beat
- dram_read_data_valid  out  1  one-cycle qualifier for `dram_read_data`
- dram_read_busy  out  1  a burst is active or a request is pending
- m_axi_araddr  out  DRAM_ADDR_WIDTH  AR address
- m_axi_arlen  out  8  AR length
- m_axi_arsize  out  3  fixed 3'b100
- m_axi_arburst  out  2  fixed 2'b01 (INCR)
- m_axi_arid  out  AXI_ID_WIDTH  fixed AXI_ID
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rdata  in  DRAM_DATA_WIDTH  R data
- m_axi_rresp  in  2  R response
- m_axi_rlast  in  1  R last
- m_axi_rid  in  AXI_ID_WIDTH  ignored
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- error_clear  in  1  clears all sticky flags
- read_error  out  1  sticky: RRESP != OKAY, or RLAST position mismatch
- boundary_error  out  1  sticky: issued burst crosses a 4 KB boundary
- req_dropped  out  1  sticky: request arrived while the pending slot was full

Behaviour:
- Reset: all outputs 0, `m_axi_arsize` and `m_axi_arburst` excepted (constant); state IDLE; pending slot empty; beat counter 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - `dram_read_en` (or a valid pending slot) latches `{addr, len}`.
  - `araddr[3:0]` is forced to 0.
  - Next state is ADDR; `m_axi_arvalid` and `dram_read_busy` rise on the cycle after `en`.
  - Pending is preferred over a new `en` in the same cycle; the new `en` is then placed in pending.
- ADDR:
  - `arvalid`, `araddr` and `arlen` stay stable until `arready`.
  - On `arvalid && arready`, go to DATA with beat counter = 0.
- DATA:
  - `m_axi_rready` = `!dram_buffer_full` (combinational); it is 0 in IDLE and ADDR.
  - On an R handshake, `dram_read_data` <= `rdata` and `dram_read_data_valid` = 1 on the next cycle only (one-cycle latency, one pulse per beat).
  - Counter increments per beat.
  - The burst ends on the beat with `rlast`.
  - If the counter equals `len` without `rlast`, or `rlast` arrives early, set `read_error`; termination still follows `rlast`.
  - On the `rlast` beat: if pending is valid, go to ADDR with the pending request (pending is cleared); otherwise go to IDLE.
- Any beat with `rresp != 2'b00` sets `read_error`; its data is still forwarded.
- `dram_read_busy` = (state != IDLE) || pending_valid, registered. It falls on the cycle after the final `rlast` beat when pending is empty.
- `dram_read_en` while not in IDLE:
  - Captured into pending if pending is empty.
  - If pending is full, the request is discarded and `req_dropped` is set.
  - An `en` in the same cycle as the final `rlast` beat counts as non-IDLE and goes to pending.
- 4 KB check: at latch, if `addr[11:0] + (len+1)*16 > 4096`, set `boundary_error`. The burst is still issued unmodified. Compute in 13 bits.
- `error_clear` has priority below a same-cycle set: set wins.
- Reset mid-burst: FSM returns to IDLE immediately; outstanding R beats after reset release are not accepted (`rready` = 0 in IDLE).

Decomposition:
- Package `image_dram_pkg` holds:
  - AXI constants: `BURST_INCR`, `SIZE_16B`, `RESP_OKAY`.
  - The state enum `rd_state_t` {IDLE, ADDR, DATA}.
  - `BEAT_BYTES` = 16 and `PAGE_BYTES` = 4096.
- No sub-module; the pending slot is an inline register plus valid bit.

Test Plan:
- Single burst:
  - Stimulus: `en` with addr=0x1000, len=3; `arready` after 2 cycles; 4 R beats, no stalls.
  - Response: `araddr`=0x1000, `arlen`=3, `arvalid` held 3 cycles; 4 `valid` pulses with data matching; `busy` drops one cycle after `rlast`.
- Backpressure:
  - Stimulus: `dram_buffer_full`=1 for beats 2–3 of a len=7 burst.
  - Response: `rready`=0 during the stall; exactly 8 `valid` pulses in order; no duplicates.
- Queueing:
  - Stimulus: second `en` (addr=0x2000, len=0) during DATA, then a third `en`.
  - Response: second AR issued on the cycle after the first `rlast`; third request dropped; `req_dropped`=1; `busy` continuous.
- Errors:
  - Stimulus: `rresp`=2'b10 on beat 1; separately `rlast` on beat 2 of a len=3 burst.
  - Response: `read_error`=1 in both cases; FSM returns to IDLE after `rlast`; `error_clear` returns it to 0.
- Boundary:
  - Stimulus: addr=0x0FF0, len=1.
  - Response: `boundary_error`=1; AR still issued with `araddr`=0x0FF0. Separately, addr=0x0FE7 gives `araddr`=0x0FE0.
- Reset mid-burst:
  - Stimulus: deassert `aresetn` after beat 1 of 4.
  - Response: all outputs 0 asynchronously; IDLE after release; `rready`=0; the next `en` works normally.
